// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the byte producers, the TX arbiter and the TX FIFO
// write side. The arbiter connects through the slave modport; the producer /
// FIFO side (or a bench standing in for them) uses the master modport.
interface uart_tx_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_pulse;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, grant, busy, timeout_pulse
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, grant, busy, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, message-locked arbiter in front of the UART TX FIFO.
// A requester keeps the byte path until its 'last' byte is accepted, so
// messages never interleave; an idle owner is released after TIMEOUT idle
// cycles. The output byte register drains independently of arbitration.
module uart_tx_arb #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.slave  bus
);

  localparam int          IDXW       = $clog2(NREQ);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_M1 = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  logic [NREQ-1:0]   grant_r;
  logic              busy_r;
  logic [IDXW-1:0]   owner_r;
  logic [IDXW-1:0]   last_owner_r;
  logic [15:0]       idle_cnt_r;
  logic              timeout_pulse_r;
  logic              out_valid_r;
  logic [7:0]        out_data_r;

  logic [NREQ-1:0]   req_ready_s;
  logic              any_valid_s;
  logic [IDXW-1:0]   winner_s;
  logic              owner_valid_s;
  logic              owner_last_s;
  logic [7:0]        owner_data_s;
  logic              accept_s;
  logic              timeout_hit_s;

  // One-hot encoding of a requester index.
  function automatic logic [NREQ-1:0] to_onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = {NREQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Ready only reaches the owner, and only when the output register has room.
  always_comb begin
    req_ready_s = grant_r & {NREQ{(~out_valid_r) | bus.out_ready}};
  end

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    int idx_v;
    logic found_v;
    winner_s    = last_owner_r;
    found_v     = 1'b0;
    any_valid_s = |bus.req_valid;
    for (int k = 1; k <= NREQ; k++) begin
      idx_v = (int'(last_owner_r) + k) % NREQ;
      if (!found_v && bus.req_valid[idx_v]) begin
        winner_s = IDXW'(idx_v);
        found_v  = 1'b1;
      end else begin
        found_v  = found_v;
      end
    end
  end

  // Owner-side view of the request bus and the accept / timeout decisions.
  always_comb begin
    owner_valid_s = bus.req_valid[owner_r];
    owner_last_s  = bus.req_last[owner_r];
    owner_data_s  = bus.req_data[{owner_r, 3'b000} +: 8];
    if (state_r == ST_LOCKED) begin
      accept_s      = owner_valid_s & req_ready_s[owner_r];
      timeout_hit_s = TIMEOUT_EN & ~owner_valid_s & (idle_cnt_r == TIMEOUT_M1);
    end else begin
      accept_s      = 1'b0;
      timeout_hit_s = 1'b0;
    end
  end

  // Arbitration FSM: grant, lock until last byte, idle-owner timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      grant_r         <= {NREQ{1'b0}};
      busy_r          <= 1'b0;
      owner_r         <= {IDXW{1'b0}};
      last_owner_r    <= IDXW'(NREQ - 1);
      idle_cnt_r      <= 16'd0;
      timeout_pulse_r <= 1'b0;
    end else begin
      timeout_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            state_r    <= ST_LOCKED;
            owner_r    <= winner_s;
            grant_r    <= to_onehot(winner_s);
            busy_r     <= 1'b1;
            idle_cnt_r <= 16'd0;
          end
        end
        ST_LOCKED: begin
          if (accept_s) begin
            idle_cnt_r <= 16'd0;
            if (owner_last_s) begin
              state_r      <= ST_IDLE;
              grant_r      <= {NREQ{1'b0}};
              busy_r       <= 1'b0;
              last_owner_r <= owner_r;
            end
          end else if (!owner_valid_s) begin
            // Back-pressure with a valid owner never reaches this branch,
            // so a full FIFO cannot cause a forced release.
            if (timeout_hit_s) begin
              state_r         <= ST_IDLE;
              grant_r         <= {NREQ{1'b0}};
              busy_r          <= 1'b0;
              last_owner_r    <= owner_r;
              timeout_pulse_r <= 1'b1;
            end else if (idle_cnt_r != 16'hFFFF) begin
              idle_cnt_r <= idle_cnt_r + 16'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {NREQ{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output byte register: load on accept, otherwise drain when FIFO takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= owner_data_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.req_ready     = req_ready_s;
  assign bus.grant         = grant_r;
  assign bus.busy          = busy_r;
  assign bus.timeout_pulse = timeout_pulse_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_data_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: instance A (2 requesters, timeout 8) runs directed
// message scenarios; instance B (4 requesters) runs the fairness pattern.
// A transaction-level model checks both instances every cycle; literal
// sequences and cycle distances pin the model.
module tb_uart_tx_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NREQ(2)) ifa ();
  uart_tx_arb_if #(.NREQ(4)) ifb ();

  uart_tx_arb #(.NREQ(2), .TIMEOUT(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  uart_tx_arb #(.NREQ(4), .TIMEOUT(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: owner -1 means nobody holds the path.
  typedef struct packed {
    int         owner;
    int         last_owner;
    logic       ov;
    logic [7:0] od;
    int         cnt;
    logic       pulse;
  } mdl_t;

  mdl_t ma, mb;

  logic [8:0] qa0[$];
  logic [8:0] qa1[$];
  logic       ordy_a;
  logic [7:0] stream_a[$];
  logic [7:0] stream_b[$];
  int         acc0[$];
  int         acc1[$];
  int         pulse_cyc[$];
  logic [1:0] grant_log [0:4095];

  logic [7:0] exp_rr [0:5] = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63};
  logic [7:0] exp_ni [0:5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22};
  logic [7:0] exp_bp [0:4] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(input int n);
    mdl_t m;
    m.owner = -1; m.last_owner = n - 1; m.ov = 1'b0; m.od = 8'h00;
    m.cnt = 0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] mdl_ready(input mdl_t m, input logic ordy);
    logic [3:0] r = 4'b0000;
    if (m.owner >= 0 && (!m.ov || ordy)) r[m.owner] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] mdl_grant(input mdl_t m);
    logic [3:0] g = 4'b0000;
    if (m.owner >= 0) g[m.owner] = 1'b1;
    return g;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int n, input int tmo,
                                    input logic [3:0] v, input logic [31:0] d,
                                    input logic [3:0] l, input logic ordy);
    mdl_t x = m;
    logic [3:0] rdy = mdl_ready(m, ordy);
    logic acc = 1'b0;
    x.pulse = 1'b0;
    if (m.owner < 0) begin
      for (int k = 1; k <= n; k++) begin
        int c = (m.last_owner + k) % n;
        if (v[c] && x.owner < 0) begin x.owner = c; x.cnt = 0; end
      end
    end else begin
      int o = m.owner;
      acc = v[o] && rdy[o];
      if (acc) begin
        x.od = d[8*o +: 8]; x.ov = 1'b1; x.cnt = 0;
        if (l[o]) begin x.owner = -1; x.last_owner = o; end
      end else if (!v[o]) begin
        if (tmo != 0 && m.cnt == tmo - 1) begin
          x.owner = -1; x.last_owner = o; x.pulse = 1'b1;
        end else if (m.cnt < 65535) begin
          x.cnt = m.cnt + 1;
        end
      end
    end
    if (!acc && ordy) x.ov = 1'b0;
    return x;
  endfunction

  // Producer driver for instance A: present the head of each message queue.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ifa.req_valid = {qa1.size() > 0, qa0.size() > 0};
      ifa.req_data  = {(qa1.size() > 0) ? qa1[0][7:0] : 8'h00,
                       (qa0.size() > 0) ? qa0[0][7:0] : 8'h00};
      ifa.req_last  = {(qa1.size() > 0) ? qa1[0][8] : 1'b0,
                       (qa0.size() > 0) ? qa0[0][8] : 1'b0};
      ifa.out_ready = ordy_a;
    end
  end

  // Compare process: check both DUTs against the model, log, advance.
  initial begin
    logic [3:0] rdy_a, rdy_b;
    logic [8:0] tmp;
    ma = mdl_reset(2);
    mb = mdl_reset(4);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin ma = mdl_reset(2); mb = mdl_reset(4); end
      rdy_a = mdl_ready(ma, ifa.out_ready);
      rdy_b = mdl_ready(mb, ifb.out_ready);
      chk("a_grant", {30'd0, ifa.grant}, {28'd0, mdl_grant(ma)});
      chk("a_busy", {31'd0, ifa.busy}, {31'd0, ma.owner >= 0});
      chk("a_ready", {30'd0, ifa.req_ready}, {28'd0, rdy_a});
      chk("a_out_valid", {31'd0, ifa.out_valid}, {31'd0, ma.ov});
      chk("a_out_data", {24'd0, ifa.out_data}, {24'd0, ma.od});
      chk("a_tmo_pulse", {31'd0, ifa.timeout_pulse}, {31'd0, ma.pulse});
      chk("b_grant", {28'd0, ifb.grant}, {28'd0, mdl_grant(mb)});
      chk("b_ready", {28'd0, ifb.req_ready}, {28'd0, rdy_b});
      chk("b_out_valid", {31'd0, ifb.out_valid}, {31'd0, mb.ov});
      chk("b_out_data", {24'd0, ifb.out_data}, {24'd0, mb.od});
      grant_log[cyc & 4095] = ifa.grant;
      if (ifa.out_valid && ifa.out_ready) stream_a.push_back(ifa.out_data);
      if (ifb.out_valid && ifb.out_ready) stream_b.push_back(ifb.out_data);
      if (ifa.timeout_pulse) pulse_cyc.push_back(cyc);
      if (!rst) begin
        if (rdy_a[0] && ifa.req_valid[0]) begin acc0.push_back(cyc); tmp = qa0.pop_front(); end
        if (rdy_a[1] && ifa.req_valid[1]) begin acc1.push_back(cyc); tmp = qa1.pop_front(); end
        ma = mdl_step(ma, 2, 8, {2'b00, ifa.req_valid}, {16'd0, ifa.req_data},
                      {2'b00, ifa.req_last}, ifa.out_ready);
        mb = mdl_step(mb, 4, 8, ifb.req_valid, ifb.req_data, ifb.req_last, ifb.out_ready);
      end
    end
  end

  task automatic clear_logs();
    stream_a.delete(); acc0.delete(); acc1.delete(); pulse_cyc.delete();
  endtask

  task automatic push_msg(input int r, input logic [7:0] d, input logic l);
    if (r == 0) qa0.push_back({l, d});
    else        qa1.push_back({l, d});
  endtask

  task automatic wait_stream_a(input string name, input int n);
    for (int k = 0; k < 80 && stream_a.size() < n; k++) @(posedge clk);
    chk(name, stream_a.size(), n);
    #1;
  endtask

  // Directed scenarios.
  initial begin
    rst = 1'b1;
    ordy_a = 1'b1;
    ifa.req_valid = 2'b00; ifa.req_data = 16'h0000; ifa.req_last = 2'b00; ifa.out_ready = 1'b1;
    ifb.req_valid = 4'hF;  ifb.req_data = {8'd3, 8'd2, 8'd1, 8'd0};
    ifb.req_last  = 4'hF;  ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {30'd0, ifa.grant}, 32'd0);
    chk("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    rst = 1'b0;

    // Round-robin: two 3-byte messages.
    push_msg(0, 8'h41, 1'b0); push_msg(0, 8'h42, 1'b0); push_msg(0, 8'h43, 1'b1);
    push_msg(1, 8'h61, 1'b0); push_msg(1, 8'h62, 1'b0); push_msg(1, 8'h63, 1'b1);
    wait_stream_a("rr_len", 6);
    for (int i = 0; i < 6; i++) chk("rr_byte", {24'd0, stream_a[i]}, {24'd0, exp_rr[i]});
    chk("rr_burst", acc0[2] - acc0[0], 2);
    chk("rr_gap", acc1[0] - acc0[2], 2);
    chk("rr_grant0", {30'd0, grant_log[acc0[0] & 4095]}, 32'd1);
    chk("rr_grant1", {30'd0, grant_log[acc1[0] & 4095]}, 32'd2);

    // Fairness on the 4-requester instance.
    for (int k = 0; k < 60 && stream_b.size() < 8; k++) @(posedge clk);
    chk("fair_len", stream_b.size() >= 8, 1);
    for (int i = 0; i < 8; i++) chk("fair_byte", {24'd0, stream_b[i]}, i % 4);

    // No interleave: requester 1 arrives mid-message of requester 0.
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    push_msg(0, 8'h11, 1'b0); push_msg(0, 8'h12, 1'b0);
    push_msg(0, 8'h13, 1'b0); push_msg(0, 8'h14, 1'b1);
    for (int k = 0; k < 40 && acc0.size() < 2; k++) @(posedge clk);
    #1;
    push_msg(1, 8'h21, 1'b0); push_msg(1, 8'h22, 1'b1);
    wait_stream_a("ni_len", 6);
    for (int i = 0; i < 6; i++) chk("ni_byte", {24'd0, stream_a[i]}, {24'd0, exp_ni[i]});
    chk("ni_gap", acc1[0] - acc0[3], 2);

    // Back-pressure: FIFO full for 20 cycles mid-message.
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    push_msg(0, 8'h31, 1'b0); push_msg(0, 8'h32, 1'b0); push_msg(0, 8'h33, 1'b0);
    push_msg(0, 8'h34, 1'b0); push_msg(0, 8'h35, 1'b1);
    for (int k = 0; k < 40 && acc0.size() < 2; k++) @(posedge clk);
    #1;
    ordy_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_held_len", stream_a.size(), 1);
    chk("bp_held_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("bp_held_data", {24'd0, ifa.out_data}, 32'h32);
    ordy_a = 1'b1;
    wait_stream_a("bp_len", 5);
    for (int i = 0; i < 5; i++) chk("bp_byte", {24'd0, stream_a[i]}, {24'd0, exp_bp[i]});
    chk("bp_no_pulse", pulse_cyc.size(), 0);

    // Timeout: owner sends one non-last byte then goes quiet.
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    push_msg(0, 8'h10, 1'b0);
    for (int k = 0; k < 40 && acc0.size() < 1; k++) @(posedge clk);
    #1;
    push_msg(1, 8'h20, 1'b1);
    for (int k = 0; k < 40 && pulse_cyc.size() < 1; k++) @(posedge clk);
    chk("tmo_seen", pulse_cyc.size(), 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("tmo_delay", pulse_cyc[0] - acc0[0], 9);
    chk("tmo_grant_idle", {30'd0, grant_log[pulse_cyc[0] & 4095]}, 32'd0);
    chk("tmo_next_grant", {30'd0, grant_log[(pulse_cyc[0] + 1) & 4095]}, 32'd2);
    wait_stream_a("tmo_len", 2);
    chk("tmo_byte0", {24'd0, stream_a[0]}, 32'h10);
    chk("tmo_byte1", {24'd0, stream_a[1]}, 32'h20);
    chk("tmo_single", pulse_cyc.size(), 1);

    // Reset mid-message while a byte is pending.
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    push_msg(0, 8'h51, 1'b0); push_msg(0, 8'h52, 1'b1);
    push_msg(1, 8'h71, 1'b0); push_msg(1, 8'h72, 1'b0); push_msg(1, 8'h73, 1'b1);
    for (int k = 0; k < 40 && acc1.size() < 1; k++) @(posedge clk);
    #1;
    chk("mrst_pre_valid", {31'd0, ifa.out_valid}, 32'd1);
    rst = 1'b1;
    qa0.delete(); qa1.delete();
    #1;
    chk("mrst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("mrst_grant", {30'd0, ifa.grant}, 32'd0);
    chk("mrst_busy", {31'd0, ifa.busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    push_msg(0, 8'h81, 1'b1);
    push_msg(1, 8'h91, 1'b1);
    wait_stream_a("mrst_len", 2);
    chk("mrst_first", {24'd0, stream_a[0]}, 32'h81);
    chk("mrst_second", {24'd0, stream_a[1]}, 32'h91);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a scenario wedges.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule
